// File: rtl/aes_block_tx_serializer_if.sv
// Block-in / byte-out bundle between the AES-CTR pipeline, the block serializer and the UART TX.
// The serializer takes the slave view; whoever feeds blocks and drains bytes takes the master view.
interface aes_block_tx_serializer_if #(
  parameter int DATA_W = 128
);
  logic              block_valid;
  logic [DATA_W-1:0] block_data;
  logic              fifo_full;
  logic              overflow;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;

  modport master (
    output block_valid, block_data, tx_ready,
    input  fifo_full, overflow, tx_data, tx_valid, busy
  );

  modport slave (
    input  block_valid, block_data, tx_ready,
    output fifo_full, overflow, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/aes_block_tx_serializer.sv
// Buffers 128-bit ciphertext blocks in a small FIFO and streams each one MSB byte first over valid/ready.
// First byte is valid two edges after block_valid; a stalled byte holds until accepted; pushes into a full FIFO are dropped.
module aes_block_tx_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_block_tx_serializer_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  state_t            state_q,    state_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic              overflow_q, overflow_d;

  logic push_ok;
  logic pop;
  logic full;

  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    overflow_d = overflow_q;

    // Fullness is judged before any same-edge pop, so a push at full is lost even if IDLE drains one.
    push_ok = bus.block_valid && !full;
    pop     = (state_q == IDLE) && (count_q != '0);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else if (bus.block_valid) begin
      overflow_d = 1'b1;
    end

    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + PTR_W'(1);
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.tx_ready) begin
          shift_d    = shift_q << 8;
          byte_idx_d = byte_idx_q + 4'd1;
          if (byte_idx_q == 4'd15) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read after the pointers say they were written.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= bus.block_data;
    end
  end

  assign bus.tx_valid  = (state_q == SEND);
  assign bus.tx_data   = shift_q[DATA_W-1 -: 8];
  assign bus.fifo_full = full;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_aes_block_tx_serializer.sv
module tb_aes_block_tx_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_block_tx_serializer_if bus_if ();

  aes_block_tx_serializer #(.FIFO_DEPTH(4), .DATA_W(128)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt   = 0;
  logic [7:0] exp_q [$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(int s);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[127-8*k -: 8] = 8'(s * 16 + k);
    return b;
  endfunction

  task automatic push_block(logic [127:0] blk, bit expect_out);
    bus_if.block_valid = 1'b1;
    bus_if.block_data  = blk;
    if (expect_out)
      for (int k = 0; k < 16; k++) exp_q.push_back(blk[127-8*k -: 8]);
    tick();
    bus_if.block_valid = 1'b0;
  endtask

  task automatic wait_hs(int target, int budget, output int cycles);
    cycles = 0;
    while (hs_cnt < target && cycles < budget) begin
      tick();
      cycles++;
    end
    if (hs_cnt < target) chk("handshake_timeout", 128'(hs_cnt), 128'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: scoreboard compare on each accepted byte, plus hold checks during stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat   = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 128'(bus_if.tx_valid), 128'(1));
        chk("stall_hold_data", 128'(bus_if.tx_data), 128'(prev_dat));
      end
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got %0h expected no byte", bus_if.tx_data);
        end else begin
          chk("byte", 128'(bus_if.tx_data), 128'(exp_q.pop_front()));
        end
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_dat   = bus_if.tx_data;
    end
  end

  initial begin
    int  base;
    int  cyc;
    int  i;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus_if.block_valid = 1'b0;
    bus_if.block_data  = '0;
    bus_if.tx_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_tx_valid",  128'(bus_if.tx_valid),  128'(0));
    chk("rst_tx_data",   128'(bus_if.tx_data),   128'(0));
    chk("rst_busy",      128'(bus_if.busy),      128'(0));
    chk("rst_overflow",  128'(bus_if.overflow),  128'(0));
    chk("rst_fifo_full", 128'(bus_if.fifo_full), 128'(0));

    // Single block, full rate
    bus_if.tx_ready = 1'b1;
    base = hs_cnt;
    push_block(128'h00112233445566778899aabbccddeeff, 1'b1);
    chk("single_e0_valid", 128'(bus_if.tx_valid), 128'(0));
    chk("single_e0_busy",  128'(bus_if.busy),     128'(1));
    tick();
    chk("single_e1_valid", 128'(bus_if.tx_valid), 128'(1));
    chk("single_e1_data",  128'(bus_if.tx_data),  128'(8'h00));
    wait_hs(base + 16, 40, cyc);
    chk("single_cycles",     128'(cyc),              128'(16));
    chk("single_busy_after", 128'(bus_if.busy),      128'(0));
    chk("single_valid_after",128'(bus_if.tx_valid),  128'(0));

    // Backpressure with tx_ready pattern 1,0,0,1
    base = hs_cnt;
    push_block(128'h00112233445566778899aabbccddeeff, 1'b1);
    i = 0;
    while (hs_cnt < base + 16 && i < 200) begin
      bus_if.tx_ready = pat[i % 4];
      tick();
      i++;
    end
    if (hs_cnt < base + 16) chk("bp_timeout", 128'(hs_cnt), 128'(base + 16));
    bus_if.tx_ready = 1'b1;
    tick();
    chk("bp_busy_after", 128'(bus_if.busy),   128'(0));
    chk("bp_sb_empty",   128'(exp_q.size()),  128'(0));
    chk("bp_count",      128'(hs_cnt),        128'(base + 16));

    // Burst of 4 under a long stall
    bus_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int b = 1; b <= 4; b++) push_block(mk(b), 1'b1);
    repeat (100) tick();
    chk("burst_overflow",  128'(bus_if.overflow),  128'(0));
    chk("burst_fifo_full", 128'(bus_if.fifo_full), 128'(0));
    chk("burst_valid",     128'(bus_if.tx_valid),  128'(1));
    chk("burst_first",     128'(bus_if.tx_data),   128'(8'h10));
    bus_if.tx_ready = 1'b1;
    wait_hs(base + 64, 200, cyc);
    chk("burst_cycles", 128'(cyc),          128'(67));
    chk("burst_busy",   128'(bus_if.busy),  128'(0));
    chk("burst_sb",     128'(exp_q.size()), 128'(0));

    // Overflow: 6 pushes, 6th dropped
    do_reset();
    bus_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int b = 1; b <= 5; b++) push_block(mk(b), 1'b1);
    push_block(mk(6), 1'b0);
    chk("ovf_fifo_full", 128'(bus_if.fifo_full), 128'(1));
    chk("ovf_flag",      128'(bus_if.overflow),  128'(1));
    bus_if.tx_ready = 1'b1;
    wait_hs(base + 80, 300, cyc);
    repeat (30) tick();
    chk("ovf_total",  128'(hs_cnt),          128'(base + 80));
    chk("ovf_sb",     128'(exp_q.size()),    128'(0));
    chk("ovf_sticky", 128'(bus_if.overflow), 128'(1));
    chk("ovf_busy",   128'(bus_if.busy),     128'(0));

    // Push on the same edge IDLE pops from a full FIFO
    do_reset();
    bus_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int b = 1; b <= 5; b++) push_block(mk(b), 1'b1);
    chk("pwp_full",     128'(bus_if.fifo_full), 128'(1));
    chk("pwp_ovf_pre",  128'(bus_if.overflow),  128'(0));
    bus_if.tx_ready = 1'b1;
    wait_hs(base + 16, 40, cyc);
    chk("pwp_idle", 128'(bus_if.tx_valid), 128'(0));
    push_block(mk(9), 1'b0);
    chk("pwp_ovf",       128'(bus_if.overflow),  128'(1));
    chk("pwp_not_full",  128'(bus_if.fifo_full), 128'(0));
    chk("pwp_sending",   128'(bus_if.tx_valid),  128'(1));
    wait_hs(base + 80, 200, cyc);
    repeat (20) tick();
    chk("pwp_total", 128'(hs_cnt),       128'(base + 80));
    chk("pwp_sb",    128'(exp_q.size()), 128'(0));

    // Reset mid-block with 2 blocks queued
    bus_if.tx_ready = 1'b0;
    base = hs_cnt;
    for (int b = 11; b <= 13; b++) push_block(mk(b), 1'b1);
    bus_if.tx_ready = 1'b1;
    wait_hs(base + 5, 40, cyc);
    do_reset();
    chk("mid_rst_valid",    128'(bus_if.tx_valid),  128'(0));
    chk("mid_rst_busy",     128'(bus_if.busy),      128'(0));
    chk("mid_rst_overflow", 128'(bus_if.overflow),  128'(0));
    chk("mid_rst_full",     128'(bus_if.fifo_full), 128'(0));
    repeat (40) tick();
    chk("mid_rst_silent", 128'(hs_cnt), 128'(base + 5));
    push_block(mk(14), 1'b1);
    wait_hs(base + 21, 40, cyc);
    tick();
    chk("mid_rst_new_sb", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
